// File: rtl/array_elem_serializer_pkg.sv
// Shared types and defaults for the array element serializer and its helpers.
// The serializer's optional no-bubble mode is enabled by ARRAY_ELEM_SERIALIZER_B2B_EN.
package array_elem_serializer_pkg;

  localparam int unsigned ELEM_W    = 33;
  localparam int unsigned NUM_ELEMS = 4;
  localparam int unsigned IDX_W     = $clog2(NUM_ELEMS);

  typedef logic [ELEM_W-1:0] elem_t;
  typedef logic [IDX_W-1:0]  idx_t;

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } state_e;

  // Bit 32 of an element is its flag; bits 31:0 are the value.
  function automatic logic elem_flag(input elem_t e);
    return e[ELEM_W-1];
  endfunction

endpackage

// File: rtl/array_elem_select.sv
// Combinational unflatten-and-mux: picks element idx out of a flattened array
// (element 0 in the LSBs). Out-of-range indices return zero.
module array_elem_select #(
  parameter int unsigned ELEM_W    = array_elem_serializer_pkg::ELEM_W,
  parameter int unsigned NUM_ELEMS = array_elem_serializer_pkg::NUM_ELEMS,
  localparam int unsigned IdxW     = $clog2(NUM_ELEMS)
) (
  input  logic [ELEM_W*NUM_ELEMS-1:0] arr,
  input  logic [IdxW-1:0]             idx,
  output logic [ELEM_W-1:0]           elem
);

  import array_elem_serializer_pkg::*;

  // One-of-N compare per element keeps the mux free of width-mismatched multiplies.
  always_comb begin
    elem = '0;
    for (int i = 0; i < int'(NUM_ELEMS); i++) begin
      if (idx == IdxW'(i)) begin
        elem = arr[ELEM_W*i +: ELEM_W];
      end
    end
  end

endmodule

// File: rtl/array_elem_serializer.sv
// Buffers one flattened array and emits its elements one per beat over a
// valid/ready stream with index and last markers.
// Define ARRAY_ELEM_SERIALIZER_B2B_EN to accept the next array on the last
// beat of the current one (no bubble between arrays); by default a single
// idle cycle separates consecutive arrays.
module array_elem_serializer #(
  parameter int unsigned ELEM_W    = array_elem_serializer_pkg::ELEM_W,
  parameter int unsigned NUM_ELEMS = array_elem_serializer_pkg::NUM_ELEMS,
  localparam int unsigned IdxW     = $clog2(NUM_ELEMS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ELEM_W*NUM_ELEMS-1:0] in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [ELEM_W-1:0]           out_data,
  output logic [IdxW-1:0]             out_index,
  output logic                        out_last,
  output logic                        out_valid,
  input  logic                        out_ready
);

  import array_elem_serializer_pkg::*;

  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_ELEMS - 1);

  state_e                      state_q;
  logic [ELEM_W*NUM_ELEMS-1:0] arr_q, arr_d;
  logic [IdxW-1:0]             idx_q, idx_d;
  logic [ELEM_W-1:0]           sel_elem;
  logic                        is_last;
  logic                        capture;
  logic                        fire;

  assign is_last = (idx_q == LastIdx);
  assign fire    = out_valid && out_ready;
  assign capture = in_valid && in_ready;

  // Input acceptance: idle, or (b2b mode) the last beat is leaving this cycle.
  always_comb begin
    in_ready = (state_q == ST_IDLE);
`ifdef ARRAY_ELEM_SERIALIZER_B2B_EN
    if ((state_q == ST_SEND) && is_last && out_ready) begin
      in_ready = 1'b1;
    end
`endif
  end

  // Next array/index: capture restarts at element 0, a fired beat advances or wraps.
  always_comb begin
    arr_d = arr_q;
    idx_d = idx_q;
    if (capture) begin
      arr_d = in_data;
      idx_d = '0;
    end else if (fire) begin
      idx_d = is_last ? '0 : idx_q + 1'b1;
    end
  end

  // Outputs are registered from the next-state view so they appear one cycle after capture.
  array_elem_select #(
    .ELEM_W   (ELEM_W),
    .NUM_ELEMS(NUM_ELEMS)
  ) u_select (
    .arr (arr_d),
    .idx (idx_d),
    .elem(sel_elem)
  );

  // State machine plus registered output beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      arr_q     <= '0;
      idx_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
    end else begin
      arr_q     <= arr_d;
      idx_q     <= idx_d;
      out_data  <= sel_elem;
      out_index <= idx_d;
      out_last  <= (idx_d == LastIdx);
      unique case (state_q)
        ST_IDLE: begin
          if (capture) begin
            state_q   <= ST_SEND;
            out_valid <= 1'b1;
          end
        end
        ST_SEND: begin
          // A capture on the last beat (b2b mode only) keeps streaming.
          if (fire && is_last && !capture) begin
            state_q   <= ST_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_array_elem_serializer.sv
// Self-checking bench for array_elem_serializer. The reference model is a queue of
// pending elements of the held array; handshakes and expected beats derive from it.
module tb_array_elem_serializer;

  localparam int EW = 33;
  localparam int NE = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [EW*NE-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [EW-1:0]    out_data;
  logic [1:0]       out_index;
  logic             out_last;
  logic             out_valid;
  logic             out_ready;

  int checks   = 0;
  int failures = 0;

  logic [EW-1:0] q[$];
  logic          last_cap;

  always #5 clk = ~clk;

  array_elem_serializer #(
    .ELEM_W   (EW),
    .NUM_ELEMS(NE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_index(out_index),
    .out_last (out_last),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [EW*NE-1:0] rand_array();
    logic [EW*NE-1:0] a;
    for (int i = 0; i < NE; i++) begin
      a[EW*i +: EW] = {1'($urandom_range(0, 1)), 32'($urandom())};
    end
    return a;
  endfunction

  // One clock: check outputs at negedge against the model, then advance the model.
  task automatic tick();
    logic exp_valid;
    logic exp_in_ready;
    @(negedge clk);
    exp_valid    = (q.size() != 0);
    exp_in_ready = (q.size() == 0);
`ifdef ARRAY_ELEM_SERIALIZER_B2B_EN
    if (q.size() == 1 && out_ready) exp_in_ready = 1'b1;
`endif
    check("in_ready", 64'(in_ready), 64'(exp_in_ready));
    check("out_valid", 64'(out_valid), 64'(exp_valid));
    if (exp_valid) begin
      check("out_data", 64'(out_data), 64'(q[0]));
      check("out_index", 64'(out_index), 64'(NE - q.size()));
      check("out_last", 64'(out_last), 64'(q.size() == 1));
    end
    last_cap = in_valid && exp_in_ready;
    if (exp_valid && out_ready) void'(q.pop_front());
    if (last_cap) begin
      for (int i = 0; i < NE; i++) q.push_back(in_data[EW*i +: EW]);
    end
    @(posedge clk);
    #1;
  endtask

  // Present an array and hold it until the model says it was taken.
  task automatic offer(input logic [EW*NE-1:0] a);
    in_valid = 1'b1;
    in_data  = a;
    last_cap = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (last_cap) break;
    end
    if (!last_cap) check("offer_timeout", 64'(last_cap), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #3;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_index", 64'(out_index), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic drain with fixed elements.
    out_ready = 1'b1;
    offer({33'h1_FFFFFFFF, 33'h0_00000003, 33'h0_0000002A, 33'h1_00000010});
    run(6);

    // Backpressure at index 1 for three cycles.
    offer({33'h1_FFFFFFFF, 33'h0_00000003, 33'h0_0000002A, 33'h1_00000010});
    tick();
    out_ready = 1'b0;
    run(3);
    out_ready = 1'b1;
    run(5);

    // Input stall / back-to-back: second array offered while the first drains.
    offer(rand_array());
    offer(rand_array());
    run(6);

    // Back-to-back with backpressure mixed in around the last beat.
    offer(rand_array());
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = rand_array();
    run(2);
    out_ready = 1'b1;
    offer(in_data);
    run(6);

    // Reset mid-array at index 2.
    offer(rand_array());
    run(2);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_out_index", 64'(out_index), 64'd0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    run(2);
    offer(rand_array());
    run(6);

    // Randomized traffic; producer holds data until taken.
    in_valid = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!in_valid) begin
        in_valid = ($urandom_range(0, 2) != 0);
        in_data  = rand_array();
      end
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
      if (last_cap) in_valid = 1'b0;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    run(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
